// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: configurable serial pattern detector.
// Accepts up to cfg_win qualified bits per run, flags matches of the latched
// pattern on z and counts them in match_cnt.
module seq_det_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_pat,
  input  logic [2:0]       cfg_len,
  input  logic [CNT_W-1:0] cfg_win,
  input  logic             cfg_ovl,
  input  logic             start,
  input  logic             i,
  input  logic             i_vld,
  output logic [3:0]       out,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;

  logic [3:0]       cfg_pat_q;
  logic [2:0]       cfg_len_q;
  logic [CNT_W-1:0] cfg_win_q;
  logic             cfg_ovl_q;

  logic [3:0]       out_q;
  logic             z_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [2:0]       fill_q;
  logic             cfg_err_q;

  logic             cfg_legal;
  logic             accept;
  logic [3:0]       shift_d;
  logic [2:0]       fill_inc;
  logic [3:0]       len_mask;
  logic             hit;
  logic             last_bit;

  // Datapath decode: legality, acceptance, shifted value and match detection.
  always_comb begin
    cfg_legal = (cfg_len_q != 3'd0) && (cfg_len_q <= 3'd4) && (cfg_win_q != '0);
    accept    = (state_q == RUN) && i_vld;
    shift_d   = {out_q[2:0], i};
    fill_inc  = (fill_q >= 3'd4) ? 3'd4 : fill_q + 3'd1;
    case (cfg_len_q)
      3'd1:    len_mask = 4'b0001;
      3'd2:    len_mask = 4'b0011;
      3'd3:    len_mask = 4'b0111;
      default: len_mask = 4'b1111;
    endcase
    hit      = accept && (fill_inc >= cfg_len_q) &&
               (((shift_d ^ cfg_pat_q) & len_mask) == 4'b0000);
    last_bit = accept && ((bit_cnt_q + ONE) == cfg_win_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && cfg_legal) state_d = RUN;
      RUN:     if (last_bit)           state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_pat_q <= 4'b1101;
      cfg_len_q <= 3'd4;
      cfg_win_q <= CNT_W'(8);
      cfg_ovl_q <= 1'b1;
    end else if ((state_q == IDLE) && cfg_we) begin
      cfg_pat_q <= cfg_pat;
      cfg_len_q <= cfg_len;
      cfg_win_q <= cfg_win;
      cfg_ovl_q <= cfg_ovl;
    end
  end

  // Run datapath: shift register, counters, match pulse and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      z_q         <= 1'b0;
      match_cnt_q <= '0;
      bit_cnt_q   <= '0;
      fill_q      <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      z_q <= hit;
      if ((state_q == IDLE) && start) begin
        if (cfg_legal) begin
          out_q       <= '0;
          match_cnt_q <= '0;
          bit_cnt_q   <= '0;
          fill_q      <= '0;
          cfg_err_q   <= 1'b0;
        end else begin
          cfg_err_q   <= 1'b1;
        end
      end
      if (accept) begin
        out_q     <= shift_d;
        bit_cnt_q <= bit_cnt_q + ONE;
        // Non-overlapping mode restarts the fill so the next match needs fresh bits.
        fill_q    <= (hit && !cfg_ovl_q) ? 3'd0 : fill_inc;
        if (hit && (match_cnt_q != '1)) match_cnt_q <= match_cnt_q + ONE;
      end
    end
  end

  assign out       = out_q;
  assign z         = z_q;
  assign match_cnt = match_cnt_q;
  assign cfg_err   = cfg_err_q;

endmodule
